// File: rtl/sfp_rsp_pkg.sv
// sfp_rsp_pkg: shared constants for the SFP slave responder.
//   Header, opcode and status codes, word field positions, telemetry count,
//   FSM state type and a helper that packs an outgoing response word.
package sfp_rsp_pkg;

   localparam logic [7:0] HDR_CMD = 8'hA5;
   localparam logic [7:0] HDR_RSP = 8'h5A;
   localparam int         CNT_W   = 16;

   localparam logic [3:0] OP_WRITE       = 4'h1;
   localparam logic [3:0] OP_READ_STATUS = 4'h2;

   localparam logic [7:0] ST_ACK         = 8'h00;
   localparam logic [7:0] ST_NACK_OPCODE = 8'h01;
   localparam logic [7:0] ST_TEL         = 8'hFF;
   localparam logic [7:0] ST_CHK         = 8'hFE;
   localparam logic [7:0] IDX_RSP        = 8'hF0;

   localparam int TEL_CNT = 9;

   // LSB positions of the 64-bit word fields
   localparam int F_HDR_LSB  = 56;
   localparam int F_ID_LSB   = 54;
   localparam int F_ADDR_LSB = 32;
   localparam int F_IDX_LSB  = 40;
   localparam int F_STAT_LSB = 32;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DECODE = 3'd1,
      S_WR_ACK = 3'd2,
      S_SNAP   = 3'd3,
      S_TX_TEL = 3'd4,
      S_TX_RSP = 3'd5
   } state_t;

   function automatic logic [63:0] pack_word(input logic [7:0]  hdr,
                                             input logic [1:0]  id,
                                             input logic [7:0]  idx,
                                             input logic [7:0]  status,
                                             input logic [31:0] payload);
      logic [63:0] w;
      w                     = '0;
      w[F_HDR_LSB  +: 8]    = hdr;
      w[F_ID_LSB   +: 2]    = id;
      w[F_IDX_LSB  +: 8]    = idx;
      w[F_STAT_LSB +: 8]    = status;
      w[31:0]               = payload;
      return w;
   endfunction

endpackage

// File: rtl/sfp_slave_responder_if.sv
// sfp_slave_responder_if: 64-bit AXI-Stream style link (tdata/tvalid/tready).
//   master modport: drives tdata/tvalid, receives tready.
//   slave modport : receives tdata/tvalid, drives tready.
interface sfp_slave_responder_if;
   logic [63:0] tdata;
   logic        tvalid;
   logic        tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/sfp_rsp_tx_reg.sv
// sfp_rsp_tx_reg: single-entry holding register for the SFP TX stream.
//   i_clk, i_rst  : clock, async active-high reset (drops tvalid at once)
//   i_load/i_data : load a new word (only when o_can_load is high)
//   o_can_load    : register empty or its word leaves this cycle
//   m_tx          : outgoing stream; word held stable until tready
module sfp_rsp_tx_reg (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_load,
   input  logic [63:0]                   i_data,
   output logic                          o_can_load,
   sfp_slave_responder_if.master         m_tx
);

   logic        valid_q;
   logic [63:0] data_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (i_load) begin
         valid_q <= 1'b1;
         data_q  <= i_data;
      end else if (m_tx.tready) begin
         valid_q <= 1'b0;
      end
   end

   assign o_can_load  = !valid_q || m_tx.tready;
   assign m_tx.tvalid = valid_q;
   assign m_tx.tdata  = data_q;

endmodule

// File: rtl/sfp_slave_responder.sv
// sfp_slave_responder: slave endpoint of the SFP command link.
//   Accepts one command word at a time, decodes WRITE / READ_STATUS, strobes
//   writes to local logic and returns a response (plus a coherent telemetry
//   frame for READ_STATUS).
//   Ports: i_clk, i_rst (async active-high), i_sfp_en, i_sfp_id,
//          s_rx (command stream in), m_tx (response stream out),
//          nine 32-bit monitor inputs (telemetry indices 0..8),
//          o_wr_cmd/o_wr_data/o_wr_flag, o_rx_cnt/o_err_cnt, o_state.
//   Build option: SFP_RSP_CHKSUM_EN appends an XOR checksum word (index 9).
//
//   state    | meaning
//   IDLE     | ready for a command while i_sfp_en is high
//   DECODE   | check header, target id, opcode; update counters
//   WR_ACK   | write strobe, queue ACK response
//   SNAP     | capture all monitors, queue telemetry word 0
//   TX_TEL   | stream remaining telemetry words (and checksum)
//   TX_RSP   | queue the 0xF0 response word, wait until it is taken
module sfp_slave_responder
   import sfp_rsp_pkg::*;
#(
   parameter logic [7:0] P_HDR_CMD = HDR_CMD,
   parameter logic [7:0] P_HDR_RSP = HDR_RSP,
   parameter int         P_CNT_W   = CNT_W
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_sfp_en,
   input  logic [1:0]           i_sfp_id,
   sfp_slave_responder_if.slave  s_rx,
   sfp_slave_responder_if.master m_tx,
   input  logic [31:0]          i_analog_intl,
   input  logic [31:0]          i_digital_intl,
   input  logic [31:0]          i_c,
   input  logic [31:0]          i_v,
   input  logic [31:0]          i_dc_c,
   input  logic [31:0]          i_dc_v,
   input  logic [31:0]          i_phase_rms_r,
   input  logic [31:0]          i_phase_rms_s,
   input  logic [31:0]          i_phase_rms_t,
   output logic [15:0]          o_wr_cmd,
   output logic [31:0]          o_wr_data,
   output logic                 o_wr_flag,
   output logic [P_CNT_W-1:0]   o_rx_cnt,
   output logic [P_CNT_W-1:0]   o_err_cnt,
   output logic [2:0]           o_state
);

   state_t state_q, state_d;

   logic [7:0]  hdr_q;
   logic [1:0]  tgt_q;
   logic [15:0] addr_q;
   logic [31:0] data_q;
   logic [1:0]  id_q;
   logic [31:0] snap_q [TEL_CNT];
   logic [3:0]  idx_q;
   logic        rsp_loaded_q;
   logic [P_CNT_W-1:0] rx_cnt_q, err_cnt_q;
   logic [15:0] wr_cmd_q;
   logic [31:0] wr_data_q;

   logic        rx_hs, hdr_ok, tgt_ok, op_write, op_read;
   logic        tx_load, rsp_load, tx_can_load;
   logic [63:0] tx_word, rsp_word, tel_word;
   logic [31:0] tel_payload, chksum;
   logic [7:0]  tel_status;

`ifdef SFP_RSP_CHKSUM_EN
   localparam logic [3:0] LAST_TEL_IDX = 4'd9;
   always_comb begin
      chksum = '0;
      for (int i = 0; i < TEL_CNT; i++) chksum = chksum ^ snap_q[i];
   end
`else
   localparam logic [3:0] LAST_TEL_IDX = 4'd8;
   assign chksum = '0;
`endif

   assign s_rx.tready = (state_q == S_IDLE) && i_sfp_en && !i_rst;
   assign rx_hs       = s_rx.tvalid && s_rx.tready;

   assign hdr_ok   = (hdr_q == P_HDR_CMD);
   assign tgt_ok   = (tgt_q == i_sfp_id);
   assign op_write = (addr_q[15:12] == OP_WRITE);
   assign op_read  = (addr_q[15:12] == OP_READ_STATUS);

   // READ_STATUS answers ACK with a zero payload; other commands echo data
   assign rsp_word = pack_word(P_HDR_RSP, id_q, IDX_RSP,
                               (op_write || op_read) ? ST_ACK : ST_NACK_OPCODE,
                               op_read ? 32'h0 : data_q);

   always_comb begin
      tel_payload = chksum;
      for (int i = 0; i < TEL_CNT; i++)
         if (idx_q == 4'(i)) tel_payload = snap_q[i];
   end
   assign tel_status = (idx_q < 4'(TEL_CNT)) ? ST_TEL : ST_CHK;
   assign tel_word   = pack_word(P_HDR_RSP, id_q, {4'h0, idx_q}, tel_status, tel_payload);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tx_load  = 1'b0;
      rsp_load = 1'b0;
      tx_word  = '0;
      case (state_q)
         S_IDLE:
            if (rx_hs) state_d = S_DECODE;
         S_DECODE:
            if (!hdr_ok || !tgt_ok) state_d = S_IDLE;
            else if (op_write)      state_d = S_WR_ACK;
            else if (op_read)       state_d = S_SNAP;
            else                    state_d = S_TX_RSP;
         // TX register is always empty here: TX_RSP drains it before IDLE
         S_WR_ACK: begin
            tx_load  = 1'b1;
            rsp_load = 1'b1;
            tx_word  = rsp_word;
            state_d  = S_TX_RSP;
         end
         // word 0 comes straight from the live input sampled with the snapshot
         S_SNAP: begin
            tx_load = 1'b1;
            tx_word = pack_word(P_HDR_RSP, id_q, 8'h00, ST_TEL, i_analog_intl);
            state_d = S_TX_TEL;
         end
         S_TX_TEL:
            if (tx_can_load) begin
               tx_load = 1'b1;
               tx_word = tel_word;
               if (idx_q == LAST_TEL_IDX) state_d = S_TX_RSP;
            end
         S_TX_RSP:
            if (!rsp_loaded_q) begin
               if (tx_can_load) begin
                  tx_load  = 1'b1;
                  rsp_load = 1'b1;
                  tx_word  = rsp_word;
               end
            end else if (m_tx.tvalid && m_tx.tready) begin
               state_d = S_IDLE;
            end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         hdr_q        <= '0;
         tgt_q        <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         id_q         <= '0;
         snap_q       <= '{default: '0};
         idx_q        <= '0;
         rsp_loaded_q <= 1'b0;
         rx_cnt_q     <= '0;
         err_cnt_q    <= '0;
         wr_cmd_q     <= '0;
         wr_data_q    <= '0;
      end else begin
         if (rx_hs) begin
            hdr_q  <= s_rx.tdata[F_HDR_LSB  +: 8];
            tgt_q  <= s_rx.tdata[F_ID_LSB   +: 2];
            addr_q <= s_rx.tdata[F_ADDR_LSB +: 16];
            data_q <= s_rx.tdata[31:0];
         end
         if (state_q == S_DECODE) begin
            id_q         <= i_sfp_id;
            rsp_loaded_q <= 1'b0;
            if (!hdr_ok) begin
               if (~&err_cnt_q) err_cnt_q <= err_cnt_q + P_CNT_W'(1);
            end else if (tgt_ok) begin
               if (~&rx_cnt_q) rx_cnt_q <= rx_cnt_q + P_CNT_W'(1);
               if (!op_write && !op_read && ~&err_cnt_q)
                  err_cnt_q <= err_cnt_q + P_CNT_W'(1);
               if (op_write) begin
                  wr_cmd_q  <= addr_q;
                  wr_data_q <= data_q;
               end
            end
         end else if (rsp_load) begin
            rsp_loaded_q <= 1'b1;
         end
         if (state_q == S_SNAP) begin
            snap_q <= '{i_analog_intl, i_digital_intl, i_c, i_v, i_dc_c, i_dc_v,
                        i_phase_rms_r, i_phase_rms_s, i_phase_rms_t};
            idx_q  <= 4'd1;
         end else if (state_q == S_TX_TEL && tx_load) begin
            idx_q  <= idx_q + 4'd1;
         end
      end
   end

   sfp_rsp_tx_reg u_tx_reg (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (tx_load),
      .i_data     (tx_word),
      .o_can_load (tx_can_load),
      .m_tx       (m_tx)
   );

   assign o_wr_cmd  = wr_cmd_q;
   assign o_wr_data = wr_data_q;
   assign o_wr_flag = (state_q == S_WR_ACK);
   assign o_rx_cnt  = rx_cnt_q;
   assign o_err_cnt = err_cnt_q;
   assign o_state   = state_q;

endmodule
